program_loader: RTL

Boot-time program loader and instruction-memory arbiter for the Nano 9k CPU. Receives a framed program image byte-by-byte from the UART receiver and writes it as 32-bit words into instruction memory while holding the CPU in reset. Releases the CPU once the image checksum passes. Between loads, it passes the CPU fetch port straight through to the instruction memory, so the CPU, loader and memory share one address/data path.

---
 rtl/loader_pkg.sv | 17 +
 rtl/program_loader_if.sv | 28 ++
 rtl/program_loader_word_assembler.sv | 47 ++++
 rtl/program_loader.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the Nano 9k program loader: FSM encodings,
// the NOP fed to the CPU during a load, and the default frame header byte.
package loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HDR_LEN = 3'd1;
    localparam state_t ST_DATA    = 3'd2;
    localparam state_t ST_CHECK   = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;
    localparam state_t ST_FAIL    = 3'd5;

    localparam logic [31:0] NOP_INSN          = 32'h0000_0013;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/program_loader_if.sv
// Bus bundle between the loader and its environment (UART rx, CPU fetch port,
// instruction memory). master = loader side, slave = environment side.
interface program_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  cpu_rom_address;
    logic [31:0] cpu_rom_data;
    logic        cpu_hold;
    logic [7:0]  mem_address;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        load_ok;
    logic        load_err;

    modport master (
        input  rx_valid, rx_data, cpu_rom_address, mem_rdata,
        output cpu_rom_data, cpu_hold, mem_address, mem_wdata, mem_we,
        busy, load_ok, load_err
    );

    modport slave (
        output rx_valid, rx_data, cpu_rom_address, mem_rdata,
        input  cpu_rom_data, cpu_hold, mem_address, mem_wdata, mem_we,
        busy, load_ok, load_err
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word packer: shifts bytes in from the top, counts lanes,
// and pulses word_done the cycle after the fourth byte of each word.
module word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        lane_full,
    output logic        word_done
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic        done_q, done_d;

    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        done_d = 1'b0;
        if (clear) begin
            lane_d = '0;
        end else if (accept) begin
            word_d = {byte_in, word_q[31:8]};
            lane_d = lane_q + 2'd1;
            done_d = (lane_q == 2'd3);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            done_q <= done_d;
        end
    end

    assign word      = word_q;
    assign lane_full = accept && (lane_q == 2'd3);
    assign word_done = done_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader / instruction-memory arbiter: loads a framed image from UART into
// instruction memory while holding the CPU. Optional inter-byte timeout: PROGRAM_LOADER_TIMEOUT_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
    input  logic              clock,
    input  logic              reset,
    program_loader_if.master  bus
);

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  xor_q, xor_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_ok_q, load_ok_d;
    logic        load_err_q, load_err_d;

    logic        frame_start;
    logic        data_accept;
    logic        lane_full;
    logic        word_done;
    logic [31:0] word;
    logic [7:0]  last_ptr;
    logic        busy;

    assign frame_start = (state_q == ST_IDLE) && bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    assign data_accept = (state_q == ST_DATA) && bus.rx_valid;
    // L = 0 wraps to 255 here, which is exactly the last index of a 256-word frame
    assign last_ptr    = len_q - 8'd1;

    word_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (frame_start),
        .accept    (data_accept),
        .byte_in   (bus.rx_data),
        .word      (word),
        .lane_full (lane_full),
        .word_done (word_done)
    );

`ifdef PROGRAM_LOADER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        xor_d      = xor_q;
        cpu_hold_d = cpu_hold_q;
        load_ok_d  = load_ok_q;
        load_err_d = load_err_q;

        if (word_done) ptr_d = ptr_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_HDR_LEN;
                    cpu_hold_d = 1'b1;
                    load_ok_d  = 1'b0;
                    load_err_d = 1'b0;
                    ptr_d      = '0;
                    xor_d      = '0;
                end
            end
            ST_HDR_LEN: begin
                if (bus.rx_valid) begin
                    len_d   = bus.rx_data;
                    xor_d   = bus.rx_data;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    xor_d = xor_q ^ bus.rx_data;
                    if (lane_full && (ptr_q == last_ptr)) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == xor_q) begin
                        state_d   = ST_RELEASE;
                        load_ok_d = 1'b1;
                    end else begin
                        state_d    = ST_FAIL;
                        load_err_d = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                state_d    = ST_IDLE;
                cpu_hold_d = 1'b0;
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PROGRAM_LOADER_TIMEOUT_EN
        tmo_d = '0;
        if (state_q inside {ST_HDR_LEN, ST_DATA, ST_CHECK} && !bus.rx_valid) begin
            if (tmo_q == TIMEOUT_CYCLES - 1) begin
                state_d    = ST_FAIL;
                load_err_d = 1'b1;
                load_ok_d  = 1'b0;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            ptr_q      <= '0;
            xor_q      <= '0;
            cpu_hold_q <= 1'b0;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            xor_q      <= xor_d;
            cpu_hold_q <= cpu_hold_d;
            load_ok_q  <= load_ok_d;
            load_err_q <= load_err_d;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign bus.busy         = busy;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.load_ok      = load_ok_q;
    assign bus.load_err     = load_err_q;
    assign bus.mem_we       = word_done;
    assign bus.mem_wdata    = word;
    assign bus.mem_address  = busy ? ptr_q : bus.cpu_rom_address;
    assign bus.cpu_rom_data = busy ? NOP_INSN : bus.mem_rdata;

endmodule
